spi_serf: RTL

//  SPI serf (responder) end of the SPI_mnrch link: mode-3 framing, SCLK idles high, MSB first.

---
 rtl/spi_serf_if.sv | 27 ++
 rtl/spi_serf.sv | 110 +++++++++++
 2 files changed

// File: rtl/spi_serf_if.sv
// Bus bundle between an SPI monarch and the spi_serf responder.
// The serf modport sees the pins plus its local tx/rx handshake.
`timescale 1ns/1ps
interface spi_serf_if #(
  parameter int WIDTH = 16
);
  logic             SS_n;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;
  logic             wrt;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             rdy;
  logic             clr_rdy;
  logic             frm_err;

  modport slave (
    input  SS_n, SCLK, MOSI, wrt, tx_data, clr_rdy,
    output MISO, rx_data, rdy, frm_err
  );

  modport master (
    output SS_n, SCLK, MOSI, wrt, tx_data, clr_rdy,
    input  MISO, rx_data, rdy, frm_err
  );
endinterface

// File: rtl/spi_serf.sv
// SPI mode-3 responder: oversamples SS_n/SCLK/MOSI on clk, captures a WIDTH-bit
// command MSB first and returns the preloaded response word on MISO in the same frame.
`timescale 1ns/1ps
module spi_serf #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_serf_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] RESYNC = 2'd2;

  // [0] first sync flop, [1] synchronized level, [2] edge-detect history
  logic [2:0]       ss_sync, sclk_sync, mosi_sync;
  logic [1:0]       state_reg;
  logic [1:0]       fill_cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] tx_hold_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rdy_reg;
  logic             frm_err_reg;

  logic             ss_fall, ss_rise, sclk_rise;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    bit_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      mosi_sync <= 3'b000;
    end else begin
      ss_sync   <= {ss_sync[1:0], bus.SS_n};
      sclk_sync <= {sclk_sync[1:0], bus.SCLK};
      mosi_sync <= {mosi_sync[1:0], bus.MOSI};
    end
  end

  assign ss_fall   = ~ss_sync[1] & ss_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];

  // A rise coinciding with ss_rise is folded in before the bit count is judged.
  always_comb begin
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    if (sclk_rise) begin
      shift_next   = {shift_reg[WIDTH-2:0], mosi_sync[2]};
      bit_cnt_next = (bit_cnt_reg == CNT_MAX) ? bit_cnt_reg : bit_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RESYNC;
      fill_cnt_reg <= 2'd0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      tx_hold_reg  <= '0;
      rx_data_reg  <= '0;
      rdy_reg      <= 1'b0;
      frm_err_reg  <= 1'b0;
    end else begin
      frm_err_reg <= 1'b0;
      if (bus.wrt) tx_hold_reg <= bus.tx_data;
      if (bus.clr_rdy) rdy_reg <= 1'b0;
      if (fill_cnt_reg != 2'd3) fill_cnt_reg <= fill_cnt_reg + 2'd1;

      case (state_reg)
        RESYNC: begin
          // Wait for the synchronizers to fill before trusting SS_n.
          if (fill_cnt_reg == 2'd3 && ss_sync[1]) state_reg <= IDLE;
        end
        IDLE: begin
          if (ss_fall) begin
            shift_reg   <= bus.wrt ? bus.tx_data : tx_hold_reg;
            bit_cnt_reg <= '0;
            state_reg   <= ACTIVE;
          end
        end
        ACTIVE: begin
          shift_reg   <= shift_next;
          bit_cnt_reg <= bit_cnt_next;
          if (ss_rise) begin
            if (bit_cnt_next == CNT_FULL) begin
              rx_data_reg <= shift_next;
              rdy_reg     <= 1'b1;
            end else begin
              frm_err_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= RESYNC;
      endcase
    end
  end

  assign bus.MISO    = (state_reg == ACTIVE) & shift_reg[WIDTH-1];
  assign bus.rx_data = rx_data_reg;
  assign bus.rdy     = rdy_reg;
  assign bus.frm_err = frm_err_reg;
endmodule
